// File: rtl/alu_commit_arbiter.sv
// alu_commit_arbiter: round-robin arbiter that shares the single register-file
// write-back port between N_UNITS execution units.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   unit_valid        per-unit result pending
//   unit_res          per-unit result, unit k at [k*XLEN +: XLEN]
//   unit_rd           per-unit destination, unit k at [k*REG_ADDR_W +: REG_ADDR_W]
//   unit_error        per-unit error flag
//   unit_clear        combinational acknowledge (transfer or flush cycle)
//   flush             synchronous flush, drops the held entry
//   wb_ready          register-file port accepts the presented entry
//   wb_valid/wb_we    entry presented / register write enable (x0 suppressed)
//   wb_rd/wb_data     destination register / write data
//   wb_error/wb_unit  error flag / source unit index of the held entry
//   exc_valid         one-cycle error-trap pulse
//
// Optional feature: define COMMIT_ERR_TRAP_EN to build the precise error trap
// (error entries are not written, raise exc_valid and freeze until flush).
package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

module alu_commit_arbiter #(
    parameter int N_UNITS    = 4,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_UNITS-1:0]            unit_valid,
    input  logic [N_UNITS*XLEN-1:0]       unit_res,
    input  logic [N_UNITS*REG_ADDR_W-1:0] unit_rd,
    input  logic [N_UNITS-1:0]            unit_error,
    output logic [N_UNITS-1:0]            unit_clear,
    input  logic                          flush,
    input  logic                          wb_ready,
    output logic                          wb_valid,
    output logic                          wb_we,
    output logic [REG_ADDR_W-1:0]         wb_rd,
    output logic [XLEN-1:0]               wb_data,
    output logic                          wb_error,
    output logic [2:0]                    wb_unit,
    output logic                          exc_valid
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
`ifdef COMMIT_ERR_TRAP_EN
    localparam logic [1:0] TRAP = 2'd2;
`endif
    localparam logic [N_UNITS-1:0] ONE  = {{(N_UNITS-1){1'b0}}, 1'b1};
    localparam logic [2:0]         LAST = 3'(N_UNITS - 1);

    logic [1:0]         state;
    logic [2:0]         rr_ptr;
    logic [2:0]         rr_next;
    logic [2:0]         win;
    logic [3:0]         cand;
    logic [N_UNITS-1:0] eligible;
    logic [N_UNITS-1:0] rot;
    logic [N_UNITS-1:0] win_oh;
    logic               held;
    logic               any_elig;
    logic               xfer;

    assign held       = (state == HOLD);
    assign wb_valid   = held & ~flush;
    assign xfer       = wb_valid & wb_ready;
    // The held unit is masked so a transfer cannot immediately re-grant it.
    assign eligible   = unit_valid & ~(held ? ONE << wb_unit : '0);
    assign unit_clear = flush ? '1 : (xfer ? ONE << wb_unit : '0);
    assign rr_next    = (wb_unit == LAST) ? 3'd0 : wb_unit + 3'd1;
    assign win_oh     = ONE << win;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        rot      = N_UNITS'({eligible, eligible} >> rr_ptr);
        any_elig = 1'b0;
        win      = '0;
        cand     = '0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (rot[i]) begin
                any_elig = 1'b1;
                win      = (cand >= 4'(N_UNITS)) ? 3'(cand - 4'(N_UNITS)) : cand[2:0];
            end
        end
    end

`ifdef COMMIT_ERR_TRAP_EN
    logic err_xfer;
    assign err_xfer = xfer & wb_error;
    assign wb_we    = wb_valid & (wb_rd != '0) & ~wb_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exc_valid <= 1'b0;
        else
            exc_valid <= err_xfer;
    end
`else
    assign wb_we     = wb_valid & (wb_rd != '0);
    assign exc_valid = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_error <= 1'b0;
            wb_unit  <= '0;
        end else if (flush) begin
            state <= IDLE;
`ifdef COMMIT_ERR_TRAP_EN
        end else if (err_xfer) begin
            state  <= TRAP;
            rr_ptr <= rr_next;
`endif
        end else if ((state == IDLE || xfer) && any_elig) begin
            state    <= HOLD;
            wb_rd    <= REG_ADDR_W'(unit_rd >> (win * REG_ADDR_W));
            wb_data  <= XLEN'(unit_res >> (win * XLEN));
            wb_error <= |(unit_error & win_oh);
            wb_unit  <= win;
            if (xfer)
                rr_ptr <= rr_next;
        end else if (xfer) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
        end
    end
endmodule

// File: tb/tb_alu_commit_arbiter.sv
// tb_alu_commit_arbiter: directed self-checking bench for alu_commit_arbiter (N_UNITS = 4).
module tb_alu_commit_arbiter;
    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         flush      = 1'b0;
    logic         wb_ready   = 1'b0;
    logic [3:0]   unit_valid = '0;
    logic [3:0]   unit_error = '0;
    logic [127:0] unit_res   = '0;
    logic [19:0]  unit_rd    = '0;
    logic [3:0]   unit_clear;
    logic         wb_valid, wb_we, wb_error, exc_valid;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [2:0]   wb_unit;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    alu_commit_arbiter #(.N_UNITS(4), .XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .unit_valid(unit_valid), .unit_res(unit_res),
        .unit_rd(unit_rd), .unit_error(unit_error), .unit_clear(unit_clear),
        .flush(flush), .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_error(wb_error), .wb_unit(wb_unit),
        .exc_valid(exc_valid)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int k, input logic [31:0] res, input logic [4:0] rd, input logic err);
        unit_res[k*32 +: 32] = res;
        unit_rd[k*5 +: 5]    = rd;
        unit_error[k]        = err;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) set_unit(k, 32'h1000_0000 + 32'(k), 5'(k + 1), 1'b0);
        unit_valid = 4'hF;
        wb_ready   = 1'b1;
        #1;
        tests++; if ({wb_valid, wb_we, wb_rd, wb_data, wb_error, wb_unit, exc_valid, unit_clear} !== 48'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {wb_valid, wb_we, wb_rd, wb_data, wb_error, wb_unit, exc_valid, unit_clear}); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({wb_valid, wb_unit, wb_data, unit_clear} !== 40'd0) begin fails++; $display("FAIL reset_held: got %h want 0", {wb_valid, wb_unit, wb_data, unit_clear}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++) begin
            logic [2:0] e;
            e = 3'(i % 4);
            cyc();
            tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b want 1", i, wb_valid); end
            tests++; if (wb_unit !== e) begin fails++; $display("FAIL rr_unit[%0d]: got %0d want %0d", i, wb_unit, e); end
            tests++; if (unit_clear !== (4'b0001 << e)) begin fails++; $display("FAIL rr_clear[%0d]: got %b want %b", i, unit_clear, 4'b0001 << e); end
            tests++; if (wb_data !== 32'h1000_0000 + 32'(e)) begin fails++; $display("FAIL rr_data[%0d]: got %h want %h", i, wb_data, 32'h1000_0000 + 32'(e)); end
            tests++; if (wb_we !== 1'b1) begin fails++; $display("FAIL rr_we[%0d]: got %b want 1", i, wb_we); end
        end
    endtask

    task automatic test_flush();
        flush      = 1'b1;
        unit_valid = 4'b0011;
        #1;
        tests++; if (unit_clear !== 4'b1111) begin fails++; $display("FAIL flush_clear: got %b want 1111", unit_clear); end
        tests++; if ({wb_valid, wb_we} !== 2'b00) begin fails++; $display("FAIL flush_wb: got %b want 00", {wb_valid, wb_we}); end
        cyc();
        flush = 1'b0;
        #1;
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_idle: got %b want 0", wb_valid); end
        cyc();
        tests++; if ({wb_valid, wb_unit} !== {1'b1, 3'd0}) begin fails++; $display("FAIL flush_rr_kept: got unit %0d valid %b want unit 0", wb_unit, wb_valid); end
        cyc();
        unit_valid = 4'b0000;
        #1;
        tests++; if (wb_unit !== 3'd1) begin fails++; $display("FAIL flush_next: got %0d want 1", wb_unit); end
        cyc();
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_drain: got %b want 0", wb_valid); end
    endtask

    task automatic test_x0_write();
        set_unit(2, 32'hDEAD_BEEF, 5'd0, 1'b0);
        unit_valid = 4'b0100;
        cyc();
        unit_valid = 4'b0000;
        #1;
        tests++; if ({wb_valid, wb_we} !== 2'b10) begin fails++; $display("FAIL x0_we: got valid/we %b want 10", {wb_valid, wb_we}); end
        tests++; if (wb_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL x0_data: got %h want deadbeef", wb_data); end
        tests++; if (unit_clear !== 4'b0100) begin fails++; $display("FAIL x0_clear: got %b want 0100", unit_clear); end
        cyc();
        tests++; if ({wb_valid, unit_clear} !== 5'd0) begin fails++; $display("FAIL x0_idle: got %b want 00000", {wb_valid, unit_clear}); end
    endtask

    task automatic test_stall();
        wb_ready   = 1'b0;
        unit_valid = 4'b0010;
        cyc();
        unit_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if ({wb_valid, wb_unit, wb_data, unit_clear} !== {1'b1, 3'd1, 32'h1000_0001, 4'b0000}) begin fails++; $display("FAIL stall_hold[%0d]: got valid %b unit %0d data %h clear %b want 1/1/10000001/0000", i, wb_valid, wb_unit, wb_data, unit_clear); end
            cyc();
        end
        wb_ready = 1'b1;
        #1;
        tests++; if (unit_clear !== 4'b0010) begin fails++; $display("FAIL stall_release: got %b want 0010", unit_clear); end
        cyc();
        unit_valid = 4'b1000;
        #1;
        tests++; if ({wb_unit, unit_clear} !== {3'd3, 4'b1000}) begin fails++; $display("FAIL stall_next: got unit %0d clear %b want 3/1000", wb_unit, unit_clear); end
        cyc();
        unit_valid = 4'b0000;
        #1;
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL stall_drain: got %b want 0", wb_valid); end
    endtask

    task automatic test_error();
        set_unit(2, 32'hBAD0_0002, 5'd5, 1'b1);
        unit_valid = 4'b0100;
        cyc();
        unit_valid = 4'b0001;
        #1;
        tests++; if ({wb_error, wb_rd} !== {1'b1, 5'd5}) begin fails++; $display("FAIL err_entry: got err %b rd %0d want 1/5", wb_error, wb_rd); end
`ifdef COMMIT_ERR_TRAP_EN
        tests++; if (wb_we !== 1'b0) begin fails++; $display("FAIL err_we: got %b want 0", wb_we); end
`else
        tests++; if (wb_we !== 1'b1) begin fails++; $display("FAIL err_we: got %b want 1", wb_we); end
`endif
        tests++; if ({unit_clear, exc_valid} !== {4'b0100, 1'b0}) begin fails++; $display("FAIL err_clear: got clear %b exc %b want 0100/0", unit_clear, exc_valid); end
        cyc();
`ifdef COMMIT_ERR_TRAP_EN
        tests++; if ({exc_valid, wb_valid, unit_clear} !== 6'b100000) begin fails++; $display("FAIL trap_enter: got exc %b valid %b clear %b want 1/0/0000", exc_valid, wb_valid, unit_clear); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++; if ({exc_valid, wb_valid} !== 2'b00) begin fails++; $display("FAIL trap_frozen[%0d]: got exc %b valid %b want 0/0", i, exc_valid, wb_valid); end
        end
        flush = 1'b1;
        #1;
        tests++; if (unit_clear !== 4'b1111) begin fails++; $display("FAIL trap_flush: got %b want 1111", unit_clear); end
        cyc();
        flush = 1'b0;
        #1;
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL trap_idle: got %b want 0", wb_valid); end
        cyc();
`endif
        tests++; if ({wb_valid, wb_unit, exc_valid} !== {1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL err_after: got valid %b unit %0d exc %b want 1/0/0", wb_valid, wb_unit, exc_valid); end
        unit_valid = 4'b0000;
        cyc();
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL err_drain: got %b want 0", wb_valid); end
    endtask

    task automatic test_async_reset();
        wb_ready   = 1'b0;
        unit_valid = 4'b0001;
        cyc();
        tests++; if ({wb_valid, wb_unit} !== {1'b1, 3'd0}) begin fails++; $display("FAIL ares_hold: got valid %b unit %0d want 1/0", wb_valid, wb_unit); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if ({wb_valid, wb_we, wb_rd, wb_data, wb_error, wb_unit, exc_valid, unit_clear} !== 48'd0) begin fails++; $display("FAIL ares_outputs: got %h want 0", {wb_valid, wb_we, wb_rd, wb_data, wb_error, wb_unit, exc_valid, unit_clear}); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_flush();
        test_x0_write();
        test_stall();
        test_error();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_commit_arbiter.md
# alu_commit_arbiter

Round-robin commit arbiter that shares the single register-file write-back port between N execution units (alu0-class units exposing valid/res/o_rd/o_error/clear). Each cycle it selects one pending unit result, registers it onto the write-back port, and pulses that unit's `clear` when the port accepts the result. It sits between the execution units and the register file / commit stage. It also provides a flush path and, optionally, a precise error trap.

## Interface
- `N_UNITS`, 4: number of execution units arbitrated; 2..8.
- `XLEN`, 32: datapath width; taken from `core_config_pkg::XLEN`.
- `REG_ADDR_W`, 5: destination register index width; taken from `core_config_pkg::REG_ADDR_W`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `unit_valid` in N_UNITS: per-unit result pending.
- `unit_res` in N_UNITS*XLEN: per-unit result; unit k occupies bits [k*XLEN +: XLEN].
- `unit_rd` in N_UNITS*REG_ADDR_W: per-unit destination register; unit k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- `unit_error` in N_UNITS: per-unit error flag accompanying the result.
- `unit_clear` out N_UNITS: combinational one-cycle acknowledge to the unit whose result was consumed.
- `flush` in 1: synchronous pipeline flush.
- `wb_ready` in 1: register-file port accepts the presented result this cycle.
- `wb_valid` out 1: write-back entry presented.
- `wb_we` out 1: register write enable.
- `wb_rd` out REG_ADDR_W: destination register.
- `wb_data` out XLEN: write data.
- `wb_error` out 1: error flag of the presented entry.
- `wb_unit` out 3: index of the source unit.
- `exc_valid` out 1: one-cycle error-trap pulse; constant 0 unless the trap is compiled in.

## Operation
- FSM states: IDLE (no entry held), HOLD (entry in output register), TRAP (frozen after an error; only exists with the macro).
- Eligible set: `unit_valid` with the bit of the unit currently held in HOLD masked off.
- Selection: round-robin. The search starts at `rr_ptr` and ascends modulo N_UNITS. The first eligible unit wins.
- IDLE:
  - If any unit is eligible and `flush` = 0, capture the winner's res/rd/error/index into the output register and go to HOLD.
  - Otherwise stay in IDLE.
- HOLD: `wb_valid` = 1. Transfer is defined as `wb_valid & wb_ready`. On a transfer:
  - `unit_clear[wb_unit]` = 1 in that cycle.
  - `rr_ptr` <= (`wb_unit` + 1) mod N_UNITS.
  - If another unit is eligible, capture it in the same edge and stay in HOLD, giving back-to-back commits.
  - Otherwise go to IDLE.
- HOLD without transfer: the output register is stable. No new capture occurs and `rr_ptr` is unchanged.
- `wb_we` = `wb_valid & (wb_rd != 0)`. A write to x0 is suppressed, but the entry is still transferred and cleared.
- `flush` = 1 in any state:
  - `unit_clear` is all ones for that cycle.
  - The held entry is dropped without a write, and `wb_valid` and `wb_we` are forced to 0 combinationally.
  - Next state is IDLE, and `rr_ptr` is unchanged.
- Reset: state IDLE and `rr_ptr` = 0. All output registers are 0: `wb_valid`, `wb_we`, `wb_rd`, `wb_data`, `wb_error`, `wb_unit`, `exc_valid`. `unit_clear` is 0.

## Timing
- Latency: a unit valid in cycle t (port idle) gives `wb_valid` in cycle t+1.
- Throughput: one commit per cycle while `wb_ready` = 1 and requests are pending.
- `unit_clear` is asserted only in the transfer cycle (or flush cycle). The unit drops `unit_valid` at the following edge.
- Simultaneous requests from all units: grant order is rr_ptr, rr_ptr+1, … with wrap-around from N_UNITS-1 to 0.
- A unit re-asserting valid immediately after its clear is not served before the other pending units.
- `wb_ready` held low: the entry is held indefinitely. Other units wait without starving, because order is preserved by `rr_ptr`.
- Flush and transfer in the same cycle: flush wins. There is no write and no `rr_ptr` update.
- Async reset mid-HOLD: the entry is lost, and the outputs go to their reset values immediately.

## Configuration
- `COMMIT_ERR_TRAP_EN` defined:
  - A held entry with `wb_error` = 1 has `wb_we` forced to 0.
  - On its transfer, `exc_valid` pulses for one cycle, the unit is cleared, and the FSM enters TRAP.
  - TRAP performs no captures, and `wb_valid` = 0.
  - Only `flush` exits TRAP, going to IDLE.
- Not defined:
  - The TRAP state is not built.
  - Error entries are written like any other entry, with `wb_error` passed through.
  - `exc_valid` is tied to 0.

## Test plan
- Reset with all units valid and rst_n low → all outputs 0. After release, the first `wb_unit` = 0 at cycle 1, and `rr_ptr` = 1 after the transfer.
- All 4 units valid continuously and `wb_ready` = 1 → `wb_unit` sequence 0,1,2,3,0. `wb_valid` stays high every cycle, and each `unit_clear[k]` pulses exactly once per grant.
- Unit 2 valid with res=0xDEADBEEF, rd=0 → `wb_valid` = 1, `wb_we` = 0, `unit_clear[2]` pulses, and the register file is unchanged.
- Unit 1 held with `wb_ready` = 0 for 5 cycles while unit 3 goes valid → outputs stable for 5 cycles. When `wb_ready` rises, unit 1 commits and then unit 3.
- `flush` in the cycle that `wb_ready` = 1 with unit 0 held → `wb_we` = 0, `unit_clear` = 4'b1111, next state IDLE, and `rr_ptr` unchanged.
- With `COMMIT_ERR_TRAP_EN`, unit 2 valid with error=1 rd=5, then unit 0 valid → `wb_we` = 0, `exc_valid` pulses once, unit 0 gets no grant until `flush`, then it commits.
